// File: rtl/mac_result_checker_if.sv
// Vector stream between the BIST driver and the MAC result checker.
// Carries the MAC operands, the MAC's actual output and a valid/ready handshake.
interface mac_result_checker_if #(
  parameter int A_WIDTH = 8,
  parameter int W_WIDTH = 8,
  parameter int P_WIDTH = 32
);

  logic               vec_valid;
  logic               vec_ready;
  logic [A_WIDTH-1:0] in_a;
  logic [W_WIDTH-1:0] in_w;
  logic [P_WIDTH-1:0] in_p;
  logic [P_WIDTH-1:0] actual_result;

  modport master (
    output vec_valid,
    output in_a,
    output in_w,
    output in_p,
    output actual_result,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  in_a,
    input  in_w,
    input  in_p,
    input  actual_result,
    output vec_ready
  );

endinterface

// File: rtl/mac_result_checker.sv
// Downstream checker for the combinational MAC in the BIST datapath.
// Recomputes (A*W)+P for every accepted vector, compares it with the MAC's
// actual output, counts mismatches and records the first failing index.
// Optional feature: define MAC_CHK_MISR_EN to add a 32-bit MISR signature
// of the actual results on output misr_sig.
module mac_result_checker #(
  parameter int A_WIDTH   = 8,
  parameter int W_WIDTH   = 8,
  parameter int P_WIDTH   = 32,
  parameter int IDX_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] num_vectors,
  mac_result_checker_if.slave  vif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic [IDX_WIDTH-1:0] first_fail_idx,
  output logic                 first_fail_vld
`ifdef MAC_CHK_MISR_EN
  ,
  output logic [31:0]          misr_sig
`endif
);

  localparam int                   PROD_WIDTH = A_WIDTH + W_WIDTH;
  localparam logic [IDX_WIDTH-1:0] IDX_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 start_ok;
  logic                 accept;
  logic                 last_accept;
  logic                 vec_ready_int;

  logic [IDX_WIDTH-1:0] num_lat;
  logic [IDX_WIDTH-1:0] acc_cnt;

  logic                 s1_vld;
  logic [A_WIDTH-1:0]   s1_a;
  logic [W_WIDTH-1:0]   s1_w;
  logic [P_WIDTH-1:0]   s1_p;
  logic [P_WIDTH-1:0]   s1_act;
  logic [IDX_WIDTH-1:0] s1_idx;

  logic signed [PROD_WIDTH-1:0] prod;
  logic [P_WIDTH-1:0]   prod_ext;
  logic [P_WIDTH-1:0]   exp_c;

  logic                 s2_vld;
  logic [P_WIDTH-1:0]   s2_exp;
  logic [P_WIDTH-1:0]   s2_act;
  logic [IDX_WIDTH-1:0] s2_idx;
  logic                 s2_bad;

  // Start is honoured only when no run is in flight; acceptance is the plain handshake.
  always_comb begin
    start_ok    = start && ((state == IDLE) || (state == DONE));
    accept      = vif.vec_valid && vec_ready_int;
    last_accept = accept && (acc_cnt == (num_lat - IDX_ONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a zero-length run completes immediately, DRAIN waits for both stages to empty.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_vld && !s2_vld) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state; pass is qualified by done.
  always_comb begin
    vec_ready_int = (state == RUN);
    busy          = (state == RUN) || (state == DRAIN);
    done          = (state == DONE);
    pass          = (state == DONE) && (fail_count == '0);
  end

  assign vif.vec_ready = vec_ready_int;

  // Stage 1: capture the accepted vector with its 0-based acceptance index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_w    <= '0;
      s1_p    <= '0;
      s1_act  <= '0;
      s1_idx  <= '0;
      acc_cnt <= '0;
      num_lat <= '0;
    end else if (start_ok) begin
      s1_vld  <= 1'b0;
      acc_cnt <= '0;
      num_lat <= num_vectors;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a    <= vif.in_a;
        s1_w    <= vif.in_w;
        s1_p    <= vif.in_p;
        s1_act  <= vif.actual_result;
        s1_idx  <= acc_cnt;
        acc_cnt <= acc_cnt + IDX_ONE;
      end
    end
  end

  // Golden value: signed product sign-extended to the result width, then a wrapping add.
  always_comb begin
    prod     = $signed(s1_a) * $signed(s1_w);
    prod_ext = {{(P_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    exp_c    = prod_ext + s1_p;
  end

  // Stage 2: hold the golden and actual values side by side for the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_exp <= '0;
      s2_act <= '0;
      s2_idx <= '0;
    end else if (start_ok) begin
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_exp <= exp_c;
        s2_act <= s1_act;
        s2_idx <= s1_idx;
      end
    end
  end

  // Full-width compare of golden against actual.
  always_comb begin
    s2_bad = s2_vld && (s2_exp != s2_act);
  end

  // Result bookkeeping: strobe, saturating counter, sticky first-failure index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch       <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (start_ok) begin
      mismatch       <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      mismatch <= s2_bad;
      if (s2_bad) begin
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + CNT_ONE;
        end
        if (!first_fail_vld) begin
          first_fail_idx <= s2_idx;
          first_fail_vld <= 1'b1;
        end
      end
    end
  end

`ifdef MAC_CHK_MISR_EN
  localparam logic [31:0] MISR_POLY = 32'h0040_0007;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  logic [31:0] misr;
  logic [31:0] misr_nxt;
  logic [31:0] act32;

  // Galois-form step for x^32+x^22+x^2+x+1, folding in one actual result.
  always_comb begin
    act32    = 32'(s1_act);
    misr_nxt = {misr[30:0], 1'b0} ^ (misr[31] ? MISR_POLY : 32'h0) ^ act32;
  end

  // Signature register: seeded on start, advanced once per vector entering stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr <= '0;
    end else if (start_ok) begin
      misr <= MISR_SEED;
    end else if (s1_vld) begin
      misr <= misr_nxt;
    end
  end

  assign misr_sig = misr;
`endif

endmodule

// File: tb/tb_mac_result_checker.sv
// Self-checking bench for mac_result_checker with randomized vectors and a
// behavioural golden model. Define MAC_CHK_MISR_EN to also check misr_sig.
module tb_mac_result_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vectors;
  logic        busy;
  logic        done;
  logic        pass;
  logic        mismatch;
  logic [15:0] fail_count;
  logic [15:0] first_fail_idx;
  logic        first_fail_vld;
`ifdef MAC_CHK_MISR_EN
  logic [31:0] misr_sig;
`endif

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int mm_pulses = 0;
  int last_acc  = 0;

  mac_result_checker_if #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32)) vif ();

  mac_result_checker #(
    .A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32), .IDX_WIDTH(16), .CNT_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vectors    (num_vectors),
    .vif            (vif),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch       (mismatch),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld)
`ifdef MAC_CHK_MISR_EN
    ,
    .misr_sig       (misr_sig)
`endif
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time acceptance, mismatch and done.
  always @(posedge clk) cyc = cyc + 1;

  // Counts mismatch strobes, sampled midway between active edges.
  always @(negedge clk) if (mismatch === 1'b1) mm_pulses = mm_pulses + 1;

  // Golden MAC result from plain integer arithmetic, wrapped to 32 bits.
  function automatic logic [31:0] golden(input logic [7:0] a, input logic [7:0] w,
                                         input logic [31:0] p);
    longint r;
    r = longint'($signed(a)) * longint'($signed(w)) + longint'($signed(p));
    return r[31:0];
  endfunction

`ifdef MAC_CHK_MISR_EN
  // Signature model: multiply state by x modulo the polynomial, then add the data word.
  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] d);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ 33'h1_0040_0007;
    return t[31:0] ^ d;
  endfunction
`endif

  // Presents one vector and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] w,
                               input logic [31:0] p, input logic [31:0] act);
    bit got;
    bit rdy;
    got = 1'b0;
    vif.in_a          = a;
    vif.in_w          = w;
    vif.in_p          = p;
    vif.actual_result = act;
    vif.vec_valid     = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      rdy = vif.vec_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        got      = 1'b1;
        last_acc = cyc;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept_timeout: vec_ready stayed %0b, required 1", vif.vec_ready);
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_vectors = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    dc = cyc;
    if (!got) begin
      errors++;
      checks++;
      $display("[TB] FAIL done_timeout: done=%0b, required 1", done);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    start         = 1'b0;
    num_vectors   = '0;
    vif.vec_valid = 1'b0;
    vif.in_a      = '0;
    vif.in_w      = '0;
    vif.in_p      = '0;
    vif.actual_result = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, mismatch, first_fail_vld, vif.vec_ready, fail_count, first_fail_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b pass=%0b mm=%0b vld=%0b rdy=%0b cnt=%0d idx=%0d, required all 0",
               busy, done, pass, mismatch, first_fail_vld, vif.vec_ready, fail_count, first_fail_idx);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, vif.vec_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%0b done=%0b rdy=%0b, required 000", busy, done, vif.vec_ready);
    end
  endtask

  task automatic test_basic();
    int dc;
    int mm0;
    logic [31:0] act;
    mm0 = mm_pulses;
    act = 32'd22;
    do_start(16'd1);
    applyStimulus(8'd3, 8'd4, 32'd10, act);
    vif.vec_valid = 1'b0;
    wait_done(dc);
    checks++;
    if ((mm_pulses - mm0) !== ((golden(8'd3, 8'd4, 32'd10) != act) ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL basic_mismatch_pulses: got %0d, required 0", mm_pulses - mm0);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %0b, required 1", done); end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("[TB] FAIL basic_pass: got %0b, required 1", pass); end
    checks++;
    if (fail_count !== 16'd0) begin errors++; $display("[TB] FAIL basic_fail_count: got %0d, required 0", fail_count); end
    checks++;
    if (first_fail_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_first_vld: got %0b, required 0", first_fail_vld); end
`ifdef MAC_CHK_MISR_EN
    checks++;
    if (misr_sig !== misr_ref(32'hFFFF_FFFF, act)) begin
      errors++;
      $display("[TB] FAIL basic_misr: got %08h, required %08h", misr_sig, misr_ref(32'hFFFF_FFFF, act));
    end
`endif
  endtask

  task automatic test_extremes();
    int dc;
    int mm0;
    mm0 = mm_pulses;
    do_start(16'd2);
    applyStimulus(8'h80, 8'h80, 32'd0, 32'd16384);
    applyStimulus(8'hFF, 8'd127, 32'd5, 32'hFFFF_FF86);
    vif.vec_valid = 1'b0;
    wait_done(dc);
    checks++;
    if ((mm_pulses - mm0) !== 0) begin errors++; $display("[TB] FAIL extreme_mismatch_pulses: got %0d, required 0", mm_pulses - mm0); end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("[TB] FAIL extreme_pass: got %0b, required 1", pass); end
    checks++;
    if (fail_count !== 16'd0) begin errors++; $display("[TB] FAIL extreme_fail_count: got %0d, required 0", fail_count); end
  endtask

  task automatic test_wrap();
    int dc;
    int acc;
    logic exp_bad;
    exp_bad = (golden(8'd1, 8'd1, 32'h7FFF_FFFF) != 32'h7FFF_FFFF);
    do_start(16'd2);
    applyStimulus(8'd1, 8'd1, 32'h7FFF_FFFF, 32'h8000_0000);
    applyStimulus(8'd1, 8'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    vif.vec_valid = 1'b0;
    acc = last_acc;
    @(posedge clk);
    #1;
    checks++;
    if (mismatch !== 1'b0) begin errors++; $display("[TB] FAIL wrap_good_no_mismatch: got %0b at acc+%0d, required 0", mismatch, cyc - acc); end
    @(posedge clk);
    #1;
    checks++;
    if (mismatch !== exp_bad) begin errors++; $display("[TB] FAIL wrap_bad_mismatch_timing: got %0b at acc+%0d, required %0b", mismatch, cyc - acc, exp_bad); end
    checks++;
    if (fail_count !== 16'd1) begin errors++; $display("[TB] FAIL wrap_fail_count: got %0d, required 1", fail_count); end
    checks++;
    if ({first_fail_vld, first_fail_idx} !== {1'b1, 16'd1}) begin
      errors++;
      $display("[TB] FAIL wrap_first_fail: got vld=%0b idx=%0d, required vld=1 idx=1", first_fail_vld, first_fail_idx);
    end
    wait_done(dc);
    checks++;
    if (pass !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pass: got %0b, required 0", pass); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ra [12];
    logic [7:0]  rw [12];
    logic [31:0] rp [12];
    logic [31:0] ract [12];
    int exp_fails;
    int exp_first;
    int first_acc;
    int dc;
    int acc;
    int mm0;
    exp_fails = 0;
    exp_first = -1;
    for (int i = 0; i < 12; i++) begin
      ra[i]   = 8'($urandom_range(0, 255));
      rw[i]   = 8'($urandom_range(0, 255));
      rp[i]   = $urandom;
      ract[i] = golden(ra[i], rw[i], rp[i]);
      if (i == 5 || i == 9) ract[i] = ract[i] ^ ($urandom | 32'd1);
    end
    for (int i = 0; i < 12; i++) begin
      if (golden(ra[i], rw[i], rp[i]) != ract[i]) begin
        exp_fails++;
        if (exp_first < 0) exp_first = i;
      end
    end
    mm0 = mm_pulses;
    do_start(16'd12);
    first_acc = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(ra[i], rw[i], rp[i], ract[i]);
      if (i == 0) first_acc = last_acc;
      if (i == 7) begin
        vif.vec_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    vif.vec_valid = 1'b0;
    acc = last_acc;
    checks++;
    if ({vif.vec_ready, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_drain_entry: got rdy=%0b busy=%0b, required rdy=0 busy=1", vif.vec_ready, busy);
    end
    checks++;
    if ((acc - first_acc) !== 14) begin
      errors++;
      $display("[TB] FAIL b2b_throughput: got %0d cycles first-to-last, required 14", acc - first_acc);
    end
    wait_done(dc);
    checks++;
    if ((dc - acc) !== 3) begin errors++; $display("[TB] FAIL b2b_done_latency: got %0d, required 3", dc - acc); end
    checks++;
    if (fail_count !== 16'(exp_fails)) begin errors++; $display("[TB] FAIL b2b_fail_count: got %0d, required %0d", fail_count, exp_fails); end
    checks++;
    if ({first_fail_vld, first_fail_idx} !== {1'b1, 16'(exp_first)}) begin
      errors++;
      $display("[TB] FAIL b2b_first_fail: got vld=%0b idx=%0d, required vld=1 idx=%0d", first_fail_vld, first_fail_idx, exp_first);
    end
    checks++;
    if (pass !== (exp_fails == 0)) begin errors++; $display("[TB] FAIL b2b_pass: got %0b, required %0b", pass, exp_fails == 0); end
    checks++;
    if ((mm_pulses - mm0) !== exp_fails) begin
      errors++;
      $display("[TB] FAIL b2b_mismatch_pulses: got %0d, required %0d", mm_pulses - mm0, exp_fails);
    end
  endtask

  task automatic test_zero_vectors();
    bit rdy_seen;
    do_start(16'd0);
    checks++;
    if ({done, pass} !== 2'b11) begin errors++; $display("[TB] FAIL zero_done_pass: got done=%0b pass=%0b, required 11", done, pass); end
    rdy_seen = (vif.vec_ready !== 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (vif.vec_ready !== 1'b0) rdy_seen = 1'b1;
    end
    checks++;
    if (rdy_seen !== 1'b0) begin errors++; $display("[TB] FAIL zero_vec_ready: got asserted, required never"); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done_hold: got %0b, required 1", done); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0]  a;
    logic [7:0]  w;
    logic [31:0] p;
    logic [31:0] act;
    int dc;
    do_start(16'd10);
    for (int i = 0; i < 4; i++) begin
      a   = 8'($urandom_range(0, 255));
      w   = 8'($urandom_range(0, 255));
      p   = $urandom;
      act = golden(a, w, p);
      if (i == 1) act = ~act;
      applyStimulus(a, w, p, act);
    end
    vif.vec_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, fail_count} !== {1'b1, 16'd1}) begin
      errors++;
      $display("[TB] FAIL midrun_before_reset: got busy=%0b cnt=%0d, required busy=1 cnt=1", busy, fail_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, mismatch, first_fail_vld, vif.vec_ready, fail_count, first_fail_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset_outputs: got busy=%0b done=%0b pass=%0b mm=%0b vld=%0b rdy=%0b cnt=%0d idx=%0d, required all 0",
               busy, done, pass, mismatch, first_fail_vld, vif.vec_ready, fail_count, first_fail_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(16'd2);
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom_range(0, 255));
      w = 8'($urandom_range(0, 255));
      p = $urandom;
      applyStimulus(a, w, p, golden(a, w, p));
    end
    vif.vec_valid = 1'b0;
    wait_done(dc);
    checks++;
    if (pass !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_pass: got %0b, required 1", pass); end
    checks++;
    if (fail_count !== 16'd0) begin errors++; $display("[TB] FAIL post_reset_fail_count: got %0d, required 0", fail_count); end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_wrap();
    test_back_to_back();
    test_zero_vectors();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mac_result_checker.md
Name: mac_result_checker

Overview:
- Downstream response checker for the combinational MAC unit in the BIST datapath.
- Per test vector, captures the MAC's operands (in_a, in_w, in_p) and its actual_result, recomputes the golden (A*W)+P internally, and compares the two.
- Counts mismatches, records the index of the first failing vector, and reports pass/fail when a programmed vector count has been consumed.

Parameters:
- A_WIDTH, 8, activation operand width (signed)
- W_WIDTH, 8, weight operand width (signed)
- P_WIDTH, 32, partial-sum / result width (signed)
- IDX_WIDTH, 16, vector index / count width
- CNT_WIDTH, 16, mismatch counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a test run (accepted in IDLE or DONE only)
- num_vectors  in  IDX_WIDTH  vector count for the run, sampled on start
- vec_valid  in  1  operands plus actual_result are valid this cycle
- vec_ready  out  1  checker accepts a vector (high only in RUN)
- in_a  in  A_WIDTH  signed activation driven to the MAC
- in_w  in  W_WIDTH  signed weight driven to the MAC
- in_p  in  P_WIDTH  signed partial sum driven to the MAC
- actual_result  in  P_WIDTH  MAC output for the same operands
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  valid when done: fail_count==0
- mismatch  out  1  one-cycle strobe per failing vector
- fail_count  out  CNT_WIDTH  mismatches in the current run, saturating
- first_fail_idx  out  IDX_WIDTH  index of the first failing vector
- first_fail_vld  out  1  first_fail_idx holds a captured value

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal counters and pipeline valids cleared. Applies immediately, mid-run included; no partial result survives.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Clear fail_count, first_fail_vld, first_fail_idx, accept counter and pipeline valids.
  - Latch num_vectors.
  - If num_vectors==0, go to DONE with pass=1; otherwise go to RUN.
- start in RUN/DRAIN: ignored.
- RUN: vec_ready=1. A vector is accepted on vec_valid&&vec_ready. Gaps in vec_valid are allowed. When the Nth vector is accepted, go to DRAIN in the next cycle; vec_ready drops in that cycle.
- DRAIN: vec_ready=0. Wait until both pipeline stages are empty (2 cycles), then go to DONE.
- DONE: done=1, pass=(fail_count==0). Outputs hold until the next start or reset.
- Pipeline, for a vector accepted at cycle t:
  - S1 (edge t): register operands, actual_result, and the vector index (0-based acceptance order).
  - S2 (edge t+1): compute expected = sign-extended(in_a*in_w) + in_p, truncated to P_WIDTH bits (two's-complement wrap, no saturation). Compare all P_WIDTH bits against the registered actual_result.
  - The mismatch strobe and the fail_count / first_fail update are visible after edge t+2.
- fail_count saturates at 2^CNT_WIDTH-1; later mismatches still pulse mismatch.
- first_fail_idx is captured only when first_fail_vld==0; later failures do not overwrite it.
- Back-to-back vectors: one per cycle, full throughput, no bubbles.

Optional Feature:
- Macro: MAC_CHK_MISR_EN.
- Defined:
  - Adds output misr_sig [31:0].
  - A 32-bit MISR, polynomial x^32+x^22+x^2+x+1, seed 0xFFFFFFFF on start, compresses actual_result (zero-extended or truncated to 32 bits) once per vector at the S2 stage.
  - Holds its value in DONE; reset value 0.
- Undefined: no MISR logic and no misr_sig port; all other behaviour is identical.

Test Plan:
- start with num_vectors=1; vector a=3, w=4, p=10, actual=22 -> mismatch never pulses; done=1, pass=1, fail_count=0, first_fail_vld=0.
- Vector a=-128, w=-128, p=0, actual=16384, followed by a=-1, w=127, p=5, actual=-122 -> both pass; pass=1.
- Wrap case: a=1, w=1, p=0x7FFFFFFF, actual=0x80000000 -> no mismatch. Same vector with actual=0x7FFFFFFF -> mismatch=1 exactly 2 cycles after acceptance.
- num_vectors=12, back-to-back vectors with errors injected at indices 5 and 9, plus a 3-cycle vec_valid gap after index 7 -> fail_count=2, first_fail_idx=5, pass=0. done rises 3 cycles after the 12th vector is accepted.
- start with num_vectors=0 -> DONE the next cycle; pass=1; vec_ready never asserts.
- Assert rst_n=0 mid-RUN after 4 of 10 vectors -> all outputs 0 immediately. A subsequent start with num_vectors=2 and two clean vectors -> pass=1, fail_count=0.
